// File: rtl/pwm_multi_channel_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_channel_controller_pkg
// Description : Shared types and helpers for the multi-channel PWM controller.
//               Holds the controller state encoding and the channel-select
//               width helper, which keeps a 1-bit select even when NCH == 1.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_multi_channel_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } pwm_state_t;

    // Width of the channel-select port; never zero.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_multi_channel_controller_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_channel_controller_channel
// Description : One PWM channel. Holds a duty shadow register written by
//               load_en, copies it to the active duty on apply (period end
//               or run start), compares against the shared counter and
//               registers the result. INV flips the output polarity.
// Ports       : clk, rst_n      - clock, async active-low reset
//               counter [W]     - shared period counter
//               apply           - copy shadow duty into active duty
//               busy            - controller in RUN or STOPPING
//               load_en         - write duty into the shadow register
//               duty    [W]     - new duty value
//               pwm             - registered channel output
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_channel_controller_channel #(
    parameter int   W   = 8,
    parameter logic INV = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] counter,
    input  logic         apply,
    input  logic         busy,
    input  logic         load_en,
    input  logic [W-1:0] duty,
    output logic         pwm
);

    logic [W-1:0] r_duty_sh;
    logic [W-1:0] r_duty_act;
    logic         r_pwm;
    logic         w_raw;

    // duty >= period naturally yields a constant active level.
    assign w_raw = busy && (counter < r_duty_act);

    // A load coinciding with apply lands in the shadow only; the active
    // register takes the previous shadow value, so the new duty waits for
    // the next period end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_sh  <= '0;
            r_duty_act <= '0;
            r_pwm      <= 1'b0;
        end else begin
            if (load_en) begin
                r_duty_sh <= duty;
            end
            if (apply) begin
                r_duty_act <= r_duty_sh;
            end
            r_pwm <= w_raw;
        end
    end

    assign pwm = r_pwm ^ INV;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_channel_controller.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_channel_controller
// Description : NCH-channel PWM controller sharing one period counter.
//               Period and duty writes go to shadow registers and take
//               effect at the end of a period. STOP completes the current
//               period before returning to IDLE.
// Ports       : clk, rst_n        - clock, async active-low reset
//               period [W]        - period in clocks, sampled on accepted set
//               duty   [W]        - high time in clocks, sampled on load
//               ch_sel            - channel addressed by load
//               load              - write duty into shadow of ch_sel
//               set               - start (IDLE) / update period shadow
//               stop              - request graceful stop
//               rdy               - 1 in IDLE
//               busy              - 1 in RUN or STOPPING
//               period_end        - high on the last count of each period
//               pwm    [NCH]      - registered channel outputs
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_channel_controller
    import pwm_multi_channel_controller_pkg::*;
#(
    parameter int             W        = 8,
    parameter int             NCH      = 4,
    parameter logic [NCH-1:0] INV_MASK = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [W-1:0]                period,
    input  logic [W-1:0]                duty,
    input  logic [sel_width(NCH)-1:0]   ch_sel,
    input  logic                        load,
    input  logic                        set,
    input  logic                        stop,
    output logic                        rdy,
    output logic                        busy,
    output logic                        period_end,
    output logic [NCH-1:0]              pwm
);

    localparam int           SW    = sel_width(NCH);
    localparam logic [W-1:0] C_ONE = W'(1);

    pwm_state_t   r_state;
    pwm_state_t   w_next_state;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_per_sh;
    logic [W-1:0] r_per_act;
    logic         w_busy;
    logic         w_last;
    logic         w_per_ok;
    logic         w_start;
    logic         w_shadow_wr;
    logic         w_apply;

    assign w_busy     = (r_state == ST_RUN) || (r_state == ST_STOPPING);
    assign w_last     = (r_cnt == (r_per_act - C_ONE));
    assign w_per_ok   = (period != '0);
    assign period_end = w_busy && w_last;
    assign w_apply    = period_end || w_start;
    assign busy       = w_busy;
    assign rdy        = (r_state == ST_IDLE);

    // Next-state logic. STOP always beats SET; a zero period is never
    // accepted so per_act stays non-zero while busy.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_shadow_wr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (set && !stop && w_per_ok) begin
                    w_next_state = ST_RUN;
                    w_start      = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_next_state = ST_STOPPING;
                end else if (set && w_per_ok) begin
                    w_shadow_wr = 1'b1;
                end
            end
            ST_STOPPING: begin
                // A SET cancels the stop, even on the final count.
                if (set && !stop && w_per_ok) begin
                    w_next_state = ST_RUN;
                    w_shadow_wr  = 1'b1;
                end else if (w_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Period counter and period shadow/active registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_per_sh  <= '0;
            r_per_act <= '0;
        end else begin
            if (!w_busy || w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + C_ONE;
            end

            if (w_start) begin
                r_per_act <= period;
                r_per_sh  <= period;
            end else begin
                if (w_shadow_wr) begin
                    r_per_sh <= period;
                end
                if (period_end) begin
                    r_per_act <= r_per_sh;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        localparam logic [SW-1:0] C_IDX = SW'(gi);
        logic w_load_en;

        assign w_load_en = load && (ch_sel == C_IDX);

        pwm_multi_channel_controller_channel #(
            .W   (W),
            .INV (INV_MASK[gi])
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .counter (r_cnt),
            .apply   (w_apply),
            .busy    (w_busy),
            .load_en (w_load_en),
            .duty    (duty),
            .pwm     (pwm[gi])
        );
    end

endmodule
`default_nettype wire
